// File: rtl/avalon_body_regfile.sv
// Avalon-MM register file of per-body state with engine start/busy/done handshake.
// Optional done interrupt (IRQ port, CTRL.IE) enabled by AVALON_BODY_REGFILE_IRQ_EN.
module avalon_body_regfile #(
    parameter int N_BODIES = 10,
    parameter int FIELDS   = 11,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = $clog2(2 + FIELDS * N_BODIES)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  AVL_CS,
    input  logic                  AVL_READ,
    input  logic                  AVL_WRITE,
    input  logic [ADDR_W-1:0]     AVL_ADDR,
    input  logic [DATA_W/8-1:0]   AVL_BYTE_EN,
    input  logic [DATA_W-1:0]     AVL_WRITEDATA,
    output logic [DATA_W-1:0]     AVL_READDATA,
    output logic                  AVL_READDATAVALID,
    output logic                  AVL_WAITREQUEST,
    output logic                  ENG_START,
    input  logic                  ENG_DONE,
    output logic [7:0]            ENG_NUM,
    input  logic [ADDR_W-1:0]     ENG_RADDR,
    output logic [DATA_W-1:0]     ENG_RDATA,
    input  logic                  ENG_WE,
    input  logic [ADDR_W-1:0]     ENG_WADDR,
    input  logic [DATA_W-1:0]     ENG_WDATA
`ifdef AVALON_BODY_REGFILE_IRQ_EN
    ,
    output logic                  IRQ
`endif
);

    localparam int NWORDS = FIELDS * N_BODIES;
    localparam int TOP    = 2 + NWORDS;
    localparam int NBE    = DATA_W / 8;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [31:0] INFO = {8'd0, 8'(DATA_W), 8'(FIELDS), 8'(N_BODIES)};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] mem [NWORDS];
    logic [7:0]        num_q;
    logic              done_q;
    logic              err_q;
    logic              ie_q;
    logic              start_q;
    logic              busy;

    logic [15:0]       wd16;
    logic [1:0]        be2;
    logic              wr_req;
    logic              wr_take;
    logic              ctrl_wr;
    logic              ctrl_l0;
    logic              start_req;
    logic              start_go;
    logic              done_evt;
    logic              done_clr;
    logic              err_clr;
    logic              err_set;
    logic              body_wr;
    logic              num_wr;
    logic [7:0]        num_new;
    logic [15:0]       ctrl16;
    logic              unused_wd;

    function automatic logic is_body(input logic [ADDR_W-1:0] a);
        return (32'(a) >= 32'd2) && (32'(a) < 32'(TOP));
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) - 32'd2);
    endfunction

    function automatic logic [DATA_W-1:0] rd_map(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        unique case (1'b1)
            (32'(a) == 32'd0): v = DATA_W'(ctrl16);
            (32'(a) == 32'd1): v = DATA_W'(INFO);
            is_body(a):        v = mem[idx(a)];
            default:           v = '0;
        endcase
        return v;
    endfunction

    assign busy    = (state_q == BUSY);
    assign wd16    = 16'(AVL_WRITEDATA);
    assign be2     = 2'(AVL_BYTE_EN);
    assign unused_wd = ^wd16[7:4];

    // Engine write-back owns the array this cycle; Avalon writes stall.
    assign wr_req          = AVL_CS & AVL_WRITE;
    assign AVL_WAITREQUEST = wr_req & ENG_WE;
    assign wr_take         = wr_req & ~ENG_WE;

    assign ctrl_wr   = wr_take && (32'(AVL_ADDR) == 32'd0);
    assign ctrl_l0   = ctrl_wr & be2[0];
    assign start_req = ctrl_l0 & wd16[0];
    assign done_clr  = ctrl_l0 & wd16[2];
    assign err_clr   = ctrl_l0 & wd16[3];
    assign body_wr   = wr_take & is_body(AVL_ADDR);
    assign num_wr    = ctrl_wr & be2[1] & ~busy;
    assign num_new   = (wd16[15:8] > 8'(N_BODIES)) ? 8'(N_BODIES) : wd16[15:8];
    assign err_set   = (start_req & ~start_go) | (body_wr & busy);

    always_comb begin
        ctrl16       = '0;
        ctrl16[1]    = busy;
        ctrl16[2]    = done_q;
        ctrl16[3]    = err_q;
        ctrl16[4]    = ie_q;
        ctrl16[15:8] = num_q;
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        done_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A done pulse in the same cycle wins over a start request.
                if (start_req && !ENG_DONE) begin
                    state_d  = BUSY;
                    start_go = 1'b1;
                end
            end
            BUSY: begin
                if (ENG_DONE) begin
                    state_d  = IDLE;
                    done_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            num_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_go;
            done_q  <= done_evt | (done_q & ~done_clr);
            err_q   <= err_set | (err_q & ~err_clr);
            if (num_wr) begin
                num_q <= num_new;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (ENG_WE && is_body(ENG_WADDR)) begin
            mem[idx(ENG_WADDR)] <= ENG_WDATA;
        end else if (body_wr && !busy) begin
            for (int l = 0; l < NBE; l++) begin
                if (AVL_BYTE_EN[l]) begin
                    mem[idx(AVL_ADDR)][8*l +: 8] <= AVL_WRITEDATA[8*l +: 8];
                end
            end
        end
    end

    // Read sees the array before any write landing on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AVL_READDATA      <= '0;
            AVL_READDATAVALID <= 1'b0;
        end else begin
            AVL_READDATAVALID <= AVL_CS & AVL_READ;
            if (AVL_CS && AVL_READ) begin
                AVL_READDATA <= rd_map(AVL_ADDR);
            end
        end
    end

    always_comb begin
        ENG_RDATA = rd_map(ENG_RADDR);
    end

    assign ENG_START = start_q;
    assign ENG_NUM   = num_q;

`ifdef AVALON_BODY_REGFILE_IRQ_EN
    logic irq_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_l0) begin
                ie_q <= wd16[4];
            end
            irq_q <= done_q & ie_q;
        end
    end

    assign IRQ = irq_q;
`else
    assign ie_q = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_body_regfile.sv
// Scoreboard bench for avalon_body_regfile: directed plan then random traffic.
// Define AVALON_BODY_REGFILE_IRQ_EN to also exercise the interrupt.
module tb_avalon_body_regfile;

    localparam int NB  = 10;
    localparam int NF  = 11;
    localparam int AW  = 7;
    localparam int TOP = 2 + NB * NF;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          waitreq;
    logic          eng_start;
    logic          eng_done;
    logic [7:0]    eng_num;
    logic [AW-1:0] raddr;
    logic [31:0]   eng_rdata;
    logic          eng_we;
    logic [AW-1:0] waddr;
    logic [31:0]   ewd;
`ifdef AVALON_BODY_REGFILE_IRQ_EN
    logic          irq;
`endif

    int            n_tot;
    int            n_bad;
    int            cyc;
    exp_t          sb[$];
    logic [31:0]   last_rd;

    logic [31:0]   mm [TOP];
    logic [7:0]    m_num;
    logic          m_busy;
    logic          m_done;
    logic          m_err;
    logic          m_ie;
    logic          m_start;
    logic          m_irq;

    avalon_body_regfile dut (
        .CLK               (clk),
        .RESET_N           (rst_n),
        .AVL_CS            (cs),
        .AVL_READ          (rd),
        .AVL_WRITE         (wr),
        .AVL_ADDR          (addr),
        .AVL_BYTE_EN       (be),
        .AVL_WRITEDATA     (wd),
        .AVL_READDATA      (rdata),
        .AVL_READDATAVALID (rvalid),
        .AVL_WAITREQUEST   (waitreq),
        .ENG_START         (eng_start),
        .ENG_DONE          (eng_done),
        .ENG_NUM           (eng_num),
        .ENG_RADDR         (raddr),
        .ENG_RDATA         (eng_rdata),
        .ENG_WE            (eng_we),
        .ENG_WADDR         (waddr),
        .ENG_WDATA         (ewd)
`ifdef AVALON_BODY_REGFILE_IRQ_EN
        ,
        .IRQ               (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_body(input int a);
        return a >= 2 && a < TOP;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return {16'd0, m_num, 3'd0, m_ie, m_err, m_done, m_busy, 1'b0};
        if (a == 1) return 32'h0020_0B0A;
        if (is_body(a)) return mm[a];
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < TOP; i++) mm[i] = 32'd0;
        m_num = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_ie = 0; m_start = 0; m_irq = 0;
    endtask

    // Reference behaviour for one clock edge, from the inputs held this cycle.
    task automatic m_edge();
        bit take, ctrl0, sreq, sok, devt, eset;
        logic [31:0] mask;
        take  = cs && wr && !eng_we;
        ctrl0 = take && addr == 0 && be[0];
        sreq  = ctrl0 && wd[0];
        sok   = sreq && !m_busy && !eng_done;
        devt  = m_busy && eng_done;
        eset  = (sreq && !sok) || (take && m_busy && is_body(int'(addr)));
        m_irq = m_done && m_ie;
        if (eng_we && is_body(int'(waddr))) mm[waddr] = ewd;
        if (take && !m_busy && is_body(int'(addr))) begin
            mask = 0;
            for (int i = 0; i < 4; i++) if (be[i]) mask |= 32'hFF << (8 * i);
            mm[addr] = (mm[addr] & ~mask) | (wd & mask);
        end
        if (take && addr == 0 && be[1] && !m_busy)
            m_num = (wd[15:8] > NB) ? 8'(NB) : wd[15:8];
`ifdef AVALON_BODY_REGFILE_IRQ_EN
        if (ctrl0) m_ie = wd[4];
`endif
        if (devt) m_done = 1;
        else if (ctrl0 && wd[2]) m_done = 0;
        if (eset) m_err = 1;
        else if (ctrl0 && wd[3]) m_err = 0;
        if (sok) m_busy = 1;
        else if (devt) m_busy = 0;
        m_start = sok;
    endtask

    task automatic idle_in();
        cs = 0; rd = 0; wr = 0; addr = 0; be = 0; wd = 0;
        eng_we = 0; waddr = 0; ewd = 0; eng_done = 0;
        raddr = AW'($urandom_range(2, TOP - 1));
    endtask

    // One cycle: inputs already driven at posedge+1; checks at negedge.
    task automatic tick(input bit use_lit = 0, input logic [31:0] lit = 0);
        exp_t e;
        if (cs && rd) begin
            e.val = use_lit ? lit : m_read(int'(addr));
            e.due = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("waitreq", 32'(waitreq), 32'(cs && wr && eng_we));
        chk("eng_start", 32'(eng_start), 32'(m_start));
        chk("eng_num", 32'(eng_num), 32'(m_num));
        chk("eng_rdata", eng_rdata, m_read(int'(raddr)));
`ifdef AVALON_BODY_REGFILE_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic avl_wr(input int a, input logic [3:0] b, input logic [31:0] d);
        idle_in();
        cs = 1; wr = 1; addr = AW'(a); be = b; wd = d;
        tick();
        idle_in();
    endtask

    task automatic avl_rd(input int a, input logic [31:0] exp);
        idle_in();
        cs = 1; rd = 1; addr = AW'(a);
        tick(1, exp);
        idle_in();
    endtask

    task automatic nop();
        idle_in();
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("rd_valid", 32'(rvalid), 32'd1);
                chk("rd_data", rdata, sb[0].val);
                last_rd = sb[0].val;
                void'(sb.pop_front());
            end else begin
                chk("rd_idle", 32'(rvalid), 32'd0);
                chk("rd_hold", rdata, last_rd);
            end
        end
    end

    initial begin
        n_tot = 0; n_bad = 0; last_rd = 0;
        rst_n = 0;
        idle_in();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_num", 32'(eng_num), 32'd0);
        rst_n = 1;

        avl_rd(1, 32'h0020_0B0A);
        avl_rd(0, 32'h0);

        avl_wr(2, 4'hF, 32'hAABB_CCDD);
        avl_wr(2, 4'b0100, 32'h0011_0000);
        avl_rd(2, 32'hAA11_CCDD);

        avl_wr(111, 4'hF, 32'h1111_2222);
        avl_rd(111, 32'h1111_2222);
        avl_wr(120, 4'hF, 32'hDEAD_BEEF);
        avl_rd(120, 32'h0);

        avl_wr(0, 4'hF, 32'h0000_0301);
        chk("start_pulse", 32'(eng_start), 32'd1);
        nop();
        chk("start_once", 32'(eng_start), 32'd0);
        avl_wr(5, 4'hF, 32'h1234_5678);
        avl_rd(5, 32'h0);
        avl_rd(0, 32'h0000_030A);
        idle_in(); eng_done = 1; tick(); idle_in();
        avl_rd(0, 32'h0000_030C);

        avl_wr(0, 4'b0010, 32'h0000_FF00);
        chk("num_sat", 32'(eng_num), 32'd10);

        idle_in();
        cs = 1; wr = 1; addr = 7; be = 4'hF; wd = 32'h7777_0007;
        eng_we = 1; waddr = 9; ewd = 32'h9999_0009; raddr = 9;
        tick();
        tick();
        eng_we = 0;
        tick();
        idle_in();
        avl_rd(7, 32'h7777_0007);
        avl_rd(9, 32'h9999_0009);

        avl_wr(0, 4'b0001, 32'h0000_001C);
        avl_wr(0, 4'b0001, 32'h0000_0011);
        nop();
        idle_in(); eng_done = 1; tick(); idle_in();
        nop();
`ifdef AVALON_BODY_REGFILE_IRQ_EN
        chk("irq_set", 32'(irq), 32'd1);
`endif
        avl_wr(0, 4'b0001, 32'h0000_0014);
        nop();
`ifdef AVALON_BODY_REGFILE_IRQ_EN
        chk("irq_clr", 32'(irq), 32'd0);
`endif
        avl_wr(0, 4'b0001, 32'h0000_0011);
        idle_in(); eng_done = 1; tick(); idle_in();
        nop();
        idle_in();
        cs = 1; rd = 1; wr = 1; addr = 0; be = 4'b0001; wd = 32'h11;
        tick();
        idle_in();
        rst_n = 0;
        #1;
        chk("mid_rst_start", 32'(eng_start), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_num", 32'(eng_num), 32'd0);
`ifdef AVALON_BODY_REGFILE_IRQ_EN
        chk("mid_rst_irq", 32'(irq), 32'd0);
`endif
        sb.delete();
        m_reset();
        last_rd = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        avl_rd(0, 32'h0);

        for (int n = 0; n < 600; n++) begin
            int sel;
            idle_in();
            cs = ($urandom_range(0, 7) != 0);
            sel = $urandom_range(0, 2);
            rd = (sel == 0);
            wr = (sel == 1);
            sel = $urandom_range(0, 9);
            if (sel == 0) addr = 0;
            else if (sel == 1) addr = AW'($urandom_range(0, 127));
            else addr = AW'($urandom_range(2, TOP - 1));
            be = 4'($urandom);
            wd = $urandom;
            if (addr == 0) begin
                wd[15:8] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
                wd[0] = ($urandom_range(0, 3) == 0);
            end
            eng_we = ($urandom_range(0, 3) == 0);
            waddr = AW'($urandom_range(0, 127));
            ewd = $urandom;
            eng_done = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
            tick();
        end

        repeat (3) nop();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
